p_display_arbiter: RTL

//  Shares the 2-digit peripheral 7-segment display among NREQ requesters (score, timer, status, debug).

---
 rtl/p_disp_pkg.sv | 13 +
 rtl/p_tick_gen.sv | 26 ++
 rtl/p_display_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/p_disp_pkg.sv
// Shared definitions for the display arbiter: FSM states and digit code defaults.
package p_disp_pkg;

    localparam int         DIGIT_W        = 5;
    localparam logic [4:0] BLANK_CODE_DEF = 5'h1F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/p_tick_gen.sv
// Free-running prescaler producing a 1-clk dwell tick every TICK_DIV clocks.
module p_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);

    logic [W-1:0] cnt;

    // Count 0..TICK_DIV-1 and wrap; only reset restarts the phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (cnt == W'(TICK_DIV - 1))
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

    assign tick = (cnt == W'(TICK_DIV - 1));

endmodule

// File: rtl/p_display_arbiter.sv
// Round-robin owner of the 2-digit display with min/max dwell per grant.
module p_display_arbiter
    import p_disp_pkg::*;
#(
    parameter int         NREQ       = 4,
    parameter int         TICK_DIV   = 100000,
    parameter int         MIN_TICKS  = 50,
    parameter int         MAX_TICKS  = 500,
    parameter logic [4:0] BLANK_CODE = BLANK_CODE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*10-1:0]   payload,
    output logic [NREQ-1:0]      grant,
    output logic [DIGIT_W-1:0]   digit0,
    output logic [DIGIT_W-1:0]   digit1,
    output logic                 busy
);

    localparam int IW = $clog2(NREQ);
    localparam int DW = $clog2(MAX_TICKS + 1);

    arb_state_t       state, state_n;
    logic [IW-1:0]    owner, owner_n;
    logic [IW-1:0]    last, last_n;
    logic [DW-1:0]    dwell, dwell_n, dwell_inc;
    logic             tick;
    logic             release_own;
    logic [NREQ-1:0]  others;
    logic [IW:0]      pick_idle, pick_rel;
    logic [DIGIT_W-1:0] pl_d0 [NREQ];
    logic [DIGIT_W-1:0] pl_d1 [NREQ];

    p_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    for (genvar k = 0; k < NREQ; k++) begin : g_pl
        assign pl_d0[k] = payload[10*k +: 5];
        assign pl_d1[k] = payload[10*k+5 +: 5];
    end

    // First set bit of m searching upward from base+1 (wrapping); returns {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] m, input logic [IW-1:0] base);
        logic          found;
        logic [IW-1:0] idx;
        int            j;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            j = (int'(base) + i) % NREQ;
            if (!found && m[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
        return {found, idx};
    endfunction

    assign others    = req & ~(NREQ'(1) << owner);
    assign pick_idle = rr_pick(req, last);
    // Owner is excluded, so handover always lands on a different requester.
    assign pick_rel  = rr_pick(others, owner);
    assign dwell_inc = dwell + DW'(1);

    // State register: FSM state, owner, rotate pointer and dwell count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            owner <= '0;
            last  <= IW'(NREQ - 1);
            dwell <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
            dwell <= dwell_n;
        end
    end

    // Next-state: dwell accounting, release decision and same-clk handover.
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        last_n      = last;
        dwell_n     = dwell;
        release_own = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_idle[IW]) begin
                    state_n = ST_HOLD;
                    owner_n = pick_idle[IW-1:0];
                    dwell_n = '0;
                end
            end
            ST_HOLD: begin
                if (dwell >= DW'(MIN_TICKS))
                    state_n = ST_OPEN;
                else if (tick) begin
                    dwell_n = dwell_inc;
                    if (dwell_inc >= DW'(MIN_TICKS))
                        state_n = ST_OPEN;
                end
            end
            ST_OPEN: begin
                // MAX_TICKS only bites when someone else is waiting.
                if (!req[owner] || ((|others) && dwell == DW'(MAX_TICKS)))
                    release_own = 1'b1;
                else if (tick && dwell < DW'(MAX_TICKS))
                    dwell_n = dwell_inc;
            end
            default: state_n = ST_IDLE;
        endcase
        // A tick coinciding with release is dropped: the new grant starts at 0.
        if (release_own) begin
            last_n  = owner;
            dwell_n = '0;
            if (pick_rel[IW]) begin
                state_n = ST_HOLD;
                owner_n = pick_rel[IW-1:0];
            end else begin
                state_n = ST_IDLE;
            end
        end
    end

    // Registered outputs follow the next owner so digits appear with the grant edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant  <= '0;
            busy   <= 1'b0;
            digit0 <= BLANK_CODE;
            digit1 <= BLANK_CODE;
        end else if (state_n != ST_IDLE) begin
            grant  <= NREQ'(1) << owner_n;
            busy   <= 1'b1;
            digit0 <= pl_d0[owner_n];
            digit1 <= pl_d1[owner_n];
        end else begin
            grant  <= '0;
            busy   <= 1'b0;
            digit0 <= BLANK_CODE;
            digit1 <= BLANK_CODE;
        end
    end

endmodule
